// File: rtl/ceespu_text_console.sv
// 80x30 text console: turns a character stream into byte-lane writes on the
// text/colour RAM port, with cursor handling, hardware scroll and full clear.
//
// state     | meaning
// IDLE      | waiting for a character; only state that accepts one
// WR_TEXT   | write latched character at cursor cell
// WR_COLOUR | write latched attribute at cursor cell, then advance cursor
// SCR_RD    | present source cell (idx+80) on the read port
// SCR_WT    | copy read text byte to text cell idx
// SCR_WC    | copy read colour byte to colour cell idx
// CLR_T     | write FILL_CHAR to text cell idx
// CLR_C     | write latched attribute to colour cell idx
module ceespu_text_console #(
  parameter logic [24:0] TEXT_BASE   = 25'h0010000,
  parameter logic [24:0] COLOUR_BASE = 25'h0011000,
  parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
  input  logic        I_sys_clk,
  input  logic        I_rst_n,
  input  logic        I_char_valid,
  input  logic [7:0]  I_char,
  input  logic [7:0]  I_colour,
  output logic        O_char_ready,
  output logic [3:0]  O_sys_write_enable,
  output logic [24:0] O_sys_address,
  output logic [31:0] O_sys_data,
  output logic [11:0] O_rd_offset,
  input  logic [7:0]  I_text_rd_data,
  input  logic [7:0]  I_colour_rd_data,
  output logic [6:0]  O_cursor_col,
  output logic [4:0]  O_cursor_row,
  output logic        O_busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_TEXT   = 3'd1;
  localparam logic [2:0] WR_COLOUR = 3'd2;
  localparam logic [2:0] SCR_RD    = 3'd3;
  localparam logic [2:0] SCR_WT    = 3'd4;
  localparam logic [2:0] SCR_WC    = 3'd5;
  localparam logic [2:0] CLR_T     = 3'd6;
  localparam logic [2:0] CLR_C     = 3'd7;

  localparam logic [6:0]  LAST_COL   = 7'd79;
  localparam logic [4:0]  LAST_ROW   = 5'd29;
  localparam logic [11:0] LAST_SCR   = 12'd2319;
  localparam logic [11:0] LAST_CELL  = 12'd2399;
  localparam logic [11:0] ROW_CELLS  = 12'd80;

  logic [2:0]  state;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [7:0]  ch_q;
  logic [7:0]  attr_q;
  logic [7:0]  colour_q;
  logic [11:0] idx;
  logic [11:0] rd_offset;
  logic        ready_q;
  logic        full_clr;
  logic        hs;
  logic [11:0] cur_off;

  logic        wr_en;
  logic        wr_colour;
  logic [11:0] wr_off;
  logic [7:0]  wr_byte;

  assign hs      = I_char_valid & ready_q;
  assign cur_off = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};

  // ready is registered, so it trails the return to IDLE by one edge
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      ch_q      <= '0;
      attr_q    <= '0;
      colour_q  <= '0;
      idx       <= '0;
      rd_offset <= '0;
      ready_q   <= 1'b0;
      full_clr  <= 1'b0;
    end else begin
      ready_q <= (state == IDLE) && !hs;
      case (state)
        IDLE: begin
          if (hs) begin
            ch_q   <= I_char;
            attr_q <= I_colour;
            case (I_char)
              8'h0D: col <= '0;
              8'h0A: begin
                col <= '0;
                if (row == LAST_ROW) begin
                  idx       <= '0;
                  rd_offset <= ROW_CELLS;
                  state     <= SCR_RD;
                end else begin
                  row <= row + 5'd1;
                end
              end
              8'h08: begin
                if (col != 7'd0) col <= col - 7'd1;
              end
              8'h0C: begin
                idx      <= '0;
                full_clr <= 1'b1;
                state    <= CLR_T;
              end
              default: state <= WR_TEXT;
            endcase
          end
        end
        WR_TEXT: state <= WR_COLOUR;
        WR_COLOUR: begin
          if (col != LAST_COL) begin
            col   <= col + 7'd1;
            state <= IDLE;
          end else begin
            col <= '0;
            if (row != LAST_ROW) begin
              row   <= row + 5'd1;
              state <= IDLE;
            end else begin
              idx       <= '0;
              rd_offset <= ROW_CELLS;
              state     <= SCR_RD;
            end
          end
        end
        SCR_RD: state <= SCR_WT;
        SCR_WT: begin
          colour_q <= I_colour_rd_data;
          state    <= SCR_WC;
        end
        SCR_WC: begin
          idx <= idx + 12'd1;
          if (idx == LAST_SCR) begin
            state <= CLR_T;
          end else begin
            rd_offset <= idx + ROW_CELLS + 12'd1;
            state     <= SCR_RD;
          end
        end
        CLR_T: state <= CLR_C;
        CLR_C: begin
          if (idx == LAST_CELL) begin
            if (full_clr) begin
              col <= '0;
              row <= '0;
            end
            full_clr <= 1'b0;
            state    <= IDLE;
          end else begin
            idx   <= idx + 12'd1;
            state <= CLR_T;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_colour = 1'b0;
    wr_off    = idx;
    wr_byte   = 8'h00;
    case (state)
      WR_TEXT: begin
        wr_en   = 1'b1;
        wr_off  = cur_off;
        wr_byte = ch_q;
      end
      WR_COLOUR: begin
        wr_en     = 1'b1;
        wr_colour = 1'b1;
        wr_off    = cur_off;
        wr_byte   = attr_q;
      end
      SCR_WT: begin
        wr_en   = 1'b1;
        wr_byte = I_text_rd_data;
      end
      SCR_WC: begin
        wr_en     = 1'b1;
        wr_colour = 1'b1;
        wr_byte   = colour_q;
      end
      CLR_T: begin
        wr_en   = 1'b1;
        wr_byte = FILL_CHAR;
      end
      CLR_C: begin
        wr_en     = 1'b1;
        wr_colour = 1'b1;
        wr_byte   = attr_q;
      end
      default: ;
    endcase
  end

  assign O_sys_write_enable = wr_en ? (4'b0001 << wr_off[1:0]) : 4'b0000;
  assign O_sys_address      = wr_en ? ((wr_colour ? COLOUR_BASE : TEXT_BASE) +
                                       {13'b0, wr_off[11:2], 2'b00}) : 25'd0;
  assign O_sys_data         = wr_en ? {4{wr_byte}} : 32'd0;
  assign O_rd_offset        = rd_offset;
  assign O_char_ready       = ready_q;
  assign O_busy             = (state != IDLE);
  assign O_cursor_col       = col;
  assign O_cursor_row       = row;

endmodule

// File: tb/tb_ceespu_text_console.sv
// Bench for ceespu_text_console: table of characters plus hand sequences,
// with a write scoreboard fed by a screen model and a behavioural RAM.
module tb_ceespu_text_console;

  localparam logic [24:0] TEXT_BASE   = 25'h0010000;
  localparam logic [24:0] COLOUR_BASE = 25'h0011000;

  logic        I_sys_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_char_valid = 1'b0;
  logic [7:0]  I_char = 8'h00;
  logic [7:0]  I_colour = 8'h00;
  logic        O_char_ready;
  logic [3:0]  O_sys_write_enable;
  logic [24:0] O_sys_address;
  logic [31:0] O_sys_data;
  logic [11:0] O_rd_offset;
  logic [7:0]  text_rd = 8'h00;
  logic [7:0]  colour_rd = 8'h00;
  logic [6:0]  O_cursor_col;
  logic [4:0]  O_cursor_row;
  logic        O_busy;

  ceespu_text_console #(
    .TEXT_BASE(TEXT_BASE),
    .COLOUR_BASE(COLOUR_BASE),
    .FILL_CHAR(8'h20)
  ) dut (
    .I_sys_clk(I_sys_clk),
    .I_rst_n(I_rst_n),
    .I_char_valid(I_char_valid),
    .I_char(I_char),
    .I_colour(I_colour),
    .O_char_ready(O_char_ready),
    .O_sys_write_enable(O_sys_write_enable),
    .O_sys_address(O_sys_address),
    .O_sys_data(O_sys_data),
    .O_rd_offset(O_rd_offset),
    .I_text_rd_data(text_rd),
    .I_colour_rd_data(colour_rd),
    .O_cursor_col(O_cursor_col),
    .O_cursor_row(O_cursor_row),
    .O_busy(O_busy)
  );

  always #5 I_sys_clk = ~I_sys_clk;

  typedef struct packed {
    logic [3:0]  we;
    logic [24:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] at;
    int         reps;
    int         exp_col;
    int         exp_row;
    int         exp_lat;
  } vec_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         mcol = 0;
  int         mrow = 0;
  logic [7:0] ref_text [2400];
  logic [7:0] ref_col  [2400];
  logic [7:0] ram_text [2400];
  logic [7:0] ram_col  [2400];
  logic       ram_load = 1'b1;

  function automatic logic [7:0] pat_t(input int k);
    return 8'(k) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] pat_c(input int k);
    return 8'(k * 7 + 3);
  endfunction

  // behavioural RAM: byte-lane write port, one-cycle read latency
  logic [1:0]  wr_lane;
  logic [24:0] wr_rel;
  int          wr_idx;
  always_comb begin
    case (O_sys_write_enable)
      4'b0010: wr_lane = 2'd1;
      4'b0100: wr_lane = 2'd2;
      4'b1000: wr_lane = 2'd3;
      default: wr_lane = 2'd0;
    endcase
  end
  assign wr_rel = (O_sys_address >= COLOUR_BASE) ? O_sys_address - COLOUR_BASE
                                                 : O_sys_address - TEXT_BASE;
  assign wr_idx = int'(wr_rel) + int'(wr_lane);

  always @(posedge I_sys_clk) begin
    if (ram_load) begin
      for (int k = 0; k < 2400; k++) begin
        ram_text[k] <= pat_t(k);
        ram_col[k]  <= pat_c(k);
      end
    end else if (O_sys_write_enable != 4'b0000 && wr_idx >= 0 && wr_idx < 2400) begin
      if (O_sys_address >= COLOUR_BASE) ram_col[wr_idx] <= O_sys_data[8*wr_lane +: 8];
      else ram_text[wr_idx] <= O_sys_data[8*wr_lane +: 8];
    end
    text_rd   <= ram_text[(O_rd_offset < 12'd2400) ? O_rd_offset : 12'd0];
    colour_rd <= ram_col[(O_rd_offset < 12'd2400) ? O_rd_offset : 12'd0];
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input bit colour, input int off, input logic [7:0] b);
    exp_t e;
    e.we   = 4'(1 << (off % 4));
    e.addr = (colour ? COLOUR_BASE : TEXT_BASE) + 25'(off - off % 4);
    e.data = {b, b, b, b};
    exp_q.push_back(e);
    if (colour) ref_col[off] = b;
    else ref_text[off] = b;
  endtask

  task automatic model_scroll(input logic [7:0] at);
    for (int i = 0; i < 2320; i++) begin
      push_wr(1'b0, i, ref_text[i + 80]);
      push_wr(1'b1, i, ref_col[i + 80]);
    end
    for (int i = 2320; i < 2400; i++) begin
      push_wr(1'b0, i, 8'h20);
      push_wr(1'b1, i, at);
    end
  endtask

  task automatic model_char(input logic [7:0] ch, input logic [7:0] at);
    case (ch)
      8'h0D: mcol = 0;
      8'h0A: begin
        mcol = 0;
        if (mrow < 29) mrow++;
        else model_scroll(at);
      end
      8'h08: if (mcol > 0) mcol--;
      8'h0C: begin
        for (int k = 0; k < 2400; k++) begin
          push_wr(1'b0, k, 8'h20);
          push_wr(1'b1, k, at);
        end
        mcol = 0;
        mrow = 0;
      end
      default: begin
        push_wr(1'b0, mrow * 80 + mcol, ch);
        push_wr(1'b1, mrow * 80 + mcol, at);
        if (mcol < 79) mcol++;
        else begin
          mcol = 0;
          if (mrow < 29) mrow++;
          else model_scroll(at);
        end
      end
    endcase
  endtask

  task automatic send(input logic [7:0] ch, input logic [7:0] at,
                      output int lat, output int busy);
    int w;
    w = 0;
    while (!O_char_ready && w < 10000) begin
      @(posedge I_sys_clk); #1;
      w++;
    end
    if (!O_char_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_wait: ready low after %0d cycles", w);
    end
    model_char(ch, at);
    I_char = ch;
    I_colour = at;
    I_char_valid = 1'b1;
    @(posedge I_sys_clk); #1;
    I_char_valid = 1'b0;
    lat = 0;
    busy = 0;
    while (lat < 9000) begin
      if (O_busy) busy++;
      @(posedge I_sys_clk); #1;
      lat++;
      if (O_char_ready) break;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [17];
    int   lat;
    int   busy;
    int   bad;

    vecs[0]  = '{8'h41, 8'h1F, 1,  1,  0,  3};
    vecs[1]  = '{8'h0D, 8'h1F, 1,  0,  0,  1};
    vecs[2]  = '{8'h0A, 8'h1F, 5,  0,  5,  1};
    vecs[3]  = '{8'h62, 8'h2E, 79, 79, 5,  3};
    vecs[4]  = '{8'h5A, 8'h4C, 1,  0,  6,  3};
    vecs[5]  = '{8'h08, 8'h4C, 1,  0,  6,  1};
    vecs[6]  = '{8'h71, 8'h1F, 3,  3,  6,  3};
    vecs[7]  = '{8'h08, 8'h1F, 1,  2,  6,  1};
    vecs[8]  = '{8'h0A, 8'h1F, 23, 0,  29, 1};
    vecs[9]  = '{8'h78, 8'h35, 10, 10, 29, 3};
    vecs[10] = '{8'h0A, 8'h61, 1,  0,  29, 7121};
    vecs[11] = '{8'h77, 8'h1F, 79, 79, 29, 3};
    vecs[12] = '{8'h65, 8'h52, 1,  0,  29, 7123};
    vecs[13] = '{8'h0C, 8'h07, 1,  0,  0,  4801};
    vecs[14] = '{8'h0A, 8'h07, 3,  0,  3,  1};
    vecs[15] = '{8'h08, 8'h07, 1,  0,  3,  1};
    vecs[16] = '{8'h0D, 8'h07, 1,  0,  3,  1};

    for (int k = 0; k < 2400; k++) begin
      ref_text[k] = pat_t(k);
      ref_col[k]  = pat_c(k);
    end

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge I_sys_clk);
          if (O_sys_write_enable != 4'b0000) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_write: we=%b addr=%h data=%h, none expected",
                       O_sys_write_enable, O_sys_address, O_sys_data);
            end else begin
              e = exp_q.pop_front();
              if (e != {O_sys_write_enable, O_sys_address, O_sys_data}) begin
                n_fail++;
                $display("FAIL write_check: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         O_sys_write_enable, O_sys_address, O_sys_data, e.we, e.addr, e.data);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge I_sys_clk);
    #1;
    ram_load = 1'b0;
    check("rst_we", int'(O_sys_write_enable), 0);
    check("rst_addr", int'(O_sys_address), 0);
    check("rst_data", int'(O_sys_data), 0);
    check("rst_rd_offset", int'(O_rd_offset), 0);
    check("rst_busy", int'(O_busy), 0);
    check("rst_ready", int'(O_char_ready), 0);
    check("rst_col", int'(O_cursor_col), 0);
    check("rst_row", int'(O_cursor_row), 0);
    @(negedge I_sys_clk);
    I_rst_n = 1'b1;
    #1;
    check("ready_before_edge", int'(O_char_ready), 0);
    @(posedge I_sys_clk); #1;
    check("ready_first_edge", int'(O_char_ready), 1);

    for (int i = 0; i < 17; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        send(vecs[i].ch, vecs[i].at, lat, busy);
        check($sformatf("latency_v%0d", i), lat, vecs[i].exp_lat);
        check($sformatf("busy_cycles_v%0d", i), busy, vecs[i].exp_lat - 1);
      end
      check($sformatf("col_v%0d", i), int'(O_cursor_col), vecs[i].exp_col);
      check($sformatf("row_v%0d", i), int'(O_cursor_row), vecs[i].exp_row);
      if (i == 10 || i == 12 || i == 13) begin
        bad = 0;
        for (int k = 0; k < 2400; k++)
          if (ram_text[k] !== ref_text[k] || ram_col[k] !== ref_col[k]) bad++;
        check($sformatf("ram_vs_model_v%0d", i), bad, 0);
      end
      if (i == 10) begin
        check("rd_offset_hold", int'(O_rd_offset), 2399);
        bad = 0;
        for (int k = 2320; k < 2400; k++)
          if (ram_text[k] !== 8'h20 || ram_col[k] !== 8'h61) bad++;
        check("scroll_bottom_fill", bad, 0);
        check("scroll_moved_Z", int'(ram_text[399]), 8'h5A);
      end
      if (i == 13) begin
        bad = 0;
        for (int k = 0; k < 2400; k++)
          if (ram_text[k] !== 8'h20 || ram_col[k] !== 8'h07) bad++;
        check("clear_cells", bad, 0);
      end
    end

    // valid held high through the busy window must be taken only once
    model_char(8'h6B, 8'h1F);
    I_char = 8'h6B;
    I_colour = 8'h1F;
    I_char_valid = 1'b1;
    repeat (3) begin
      @(posedge I_sys_clk); #1;
    end
    check("held_ready_low", int'(O_char_ready), 0);
    I_char_valid = 1'b0;
    @(posedge I_sys_clk); #1;
    check("held_ready_back", int'(O_char_ready), 1);
    repeat (3) @(posedge I_sys_clk);
    #1;
    check("held_col", int'(O_cursor_col), 1);
    check("held_row", int'(O_cursor_row), 3);
    check("held_queue", exp_q.size(), 0);

    for (int r = 0; r < 26; r++) begin
      send(8'h0A, 8'h1F, lat, busy);
      check("lf_latency", lat, 1);
    end
    check("pre_abort_row", int'(O_cursor_row), 29);

    // reset in the middle of a scroll
    model_char(8'h0A, 8'h44);
    I_char = 8'h0A;
    I_colour = 8'h44;
    I_char_valid = 1'b1;
    @(posedge I_sys_clk); #1;
    I_char_valid = 1'b0;
    repeat (1000) @(posedge I_sys_clk);
    #1;
    check("abort_busy_before", int'(O_busy), 1);
    I_rst_n = 1'b0;
    #1;
    check("abort_we", int'(O_sys_write_enable), 0);
    check("abort_addr", int'(O_sys_address), 0);
    check("abort_col", int'(O_cursor_col), 0);
    check("abort_row", int'(O_cursor_row), 0);
    check("abort_busy", int'(O_busy), 0);
    check("abort_ready", int'(O_char_ready), 0);
    exp_q.delete();
    mcol = 0;
    mrow = 0;
    for (int k = 0; k < 2400; k++) begin
      ref_text[k] = ram_text[k];
      ref_col[k]  = ram_col[k];
    end
    repeat (2) @(posedge I_sys_clk);
    #1;
    check("abort_we_held", int'(O_sys_write_enable), 0);
    @(negedge I_sys_clk);
    I_rst_n = 1'b1;
    #1;
    check("release_ready_low", int'(O_char_ready), 0);
    @(posedge I_sys_clk); #1;
    check("release_ready_high", int'(O_char_ready), 1);

    send(8'h41, 8'h1F, lat, busy);
    check("post_latency", lat, 3);
    check("post_col", int'(O_cursor_col), 1);
    check("post_row", int'(O_cursor_row), 0);
    check("post_text0", int'(ram_text[0]), 8'h41);
    check("post_colour0", int'(ram_col[0]), 8'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
